mux_arbiter_8: RTL and testbench
================================

MUX_ARBITER_8 -- requirements
Module: mux_arbiter_8

Interface
REQ-001 SHALL have parameter: nrOfBits, default 8, width of each channel data word.
REQ-002 SHALL have port: clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on rising clock edge.
REQ-004 SHALL have port: enable  input  1  when low, no new channel is granted.
REQ-005 SHALL have port: inValid  input  8  per-channel request; bit i = channel i holds a word.
REQ-006 SHALL have port: inData  input  8*nrOfBits  channel i word at bits [i*nrOfBits +: nrOfBits].
REQ-007 SHALL have port: inReady  output  8  per-channel accept; word i transfers when inValid[i] & inReady[i].
REQ-008 SHALL have port: outValid  output  1  output register holds a word.
REQ-009 SHALL have port: outData  output  nrOfBits  selected word.
REQ-010 SHALL have port: outSel  output  3  index of channel that supplied outData.
REQ-011 SHALL have port: outReady  input  1  downstream accept; word leaves when outValid & outReady.

Function
REQ-012 SHALL contain one output register (outValid, outData, outSel); states EMPTY (outValid=0) and FULL (outValid=1).
REQ-013 SHALL define load-allowed = (outValid=0) | (outValid & outReady).
REQ-014 SHALL grant at most one channel per cycle: grant = first i with inValid[i]=1 in search order, only when enable=1 and load-allowed=1.
REQ-015 SHALL drive inReady combinationally: inReady[g]=1 for granted channel g only, all other bits 0; all bits 0 when no grant or reset=1.
REQ-016 SHALL on a grant of g load outData=word g, outSel=g, outValid=1 at the next rising edge (1-cycle latency from inValid to outValid).
REQ-017 SHALL on FULL with outReady=1 and no grant go to EMPTY next cycle; with a grant in same cycle stay FULL with new word (back-to-back, 1 word/cycle).
REQ-018 SHALL hold outData and outSel stable while outValid=1 and outReady=0.
REQ-019 SHALL with enable=0 keep any FULL word until accepted; enable affects only new grants.
REQ-020 SHALL ignore inData of channels not granted; inValid dropping without transfer is legal and loses nothing.
REQ-021 SHALL keep a 3-bit priority pointer ptr; search order is ptr, ptr+1, ... ptr+7 modulo 8.
REQ-022 SHALL on a grant of g set ptr=(g+1) mod 8 (7 wraps to 0); ptr unchanged when no grant.

Reset
REQ-023 SHALL on reset=1 at a rising edge set outValid=0, outData=0, outSel=0, ptr=0, regardless of other inputs.
REQ-024 SHALL discard a FULL word and any same-cycle grant when reset asserts mid-operation; no inReady bit is high while reset=1.
REQ-025 SHALL resume granting on the first edge after reset deasserts.

Configuration
REQ-026 SHALL use macro MUX_ARBITER_8_ROUND_ROBIN_EN to select arbitration policy.
REQ-027 SHALL, when MUX_ARBITER_8_ROUND_ROBIN_EN is defined, implement REQ-021/REQ-022 round-robin.
REQ-028 SHALL, when undefined, omit ptr and use fixed priority: lowest index i with inValid[i]=1 wins; all other behaviour unchanged.

Verification
REQ-029 SHALL cover: reset with inValid=8'hFF, outReady=1 -> inReady=0, outValid=0, outData=0, outSel=0 during reset; first grant channel 0 after release.
REQ-030 SHALL cover: inValid=8'h01, inData ch0=8'hA5, outReady=1 -> inReady=8'h01 cycle N, outValid=1, outData=8'hA5, outSel=0 cycle N+1.
REQ-031 SHALL cover (round-robin): inValid=8'hFF held, outReady=1 -> outSel sequence 0,1,...,7,0 on consecutive cycles; fixed-priority build -> outSel=0 every cycle.
REQ-032 SHALL cover: FULL with ch3=8'h3C, outReady=0 for 4 cycles, inValid=8'h10 -> outData=8'h3C, outSel=3 held, inReady=0; outReady=1 -> inReady=8'h10 same cycle, next outData=ch4, outSel=4.
REQ-033 SHALL cover: ptr=7, inValid=8'h81 -> grant 7, then ptr wraps to 0 -> next grant 0.
REQ-034 SHALL cover: enable=0 with inValid=8'h02 -> inReady=0, outValid stays 0; enable=1 -> grant channel 1 next cycle.

Source files
------------

// File: rtl/mux_arbiter_8.sv
`default_nettype none
// ============================================================================
// Module   : mux_arbiter_8
// Purpose  : Eight-channel valid/ready arbiter and multiplexer. At most one
//            requesting channel is granted per cycle, and its word is loaded
//            into a single output register (outValid/outData/outSel).
//            Back-to-back transfers run at one word per cycle.
// Policy   : Fixed priority (lowest index wins) by default. Define
//            MUX_ARBITER_8_ROUND_ROBIN_EN for round-robin arbitration with a
//            3-bit priority pointer that moves past the last granted channel.
// Ports    : clock    - rising-edge clock
//            reset    - synchronous active-high reset
//            enable   - allows new grants (a held output word is unaffected)
//            inValid  - per-channel request
//            inData   - channel i word at [i*nrOfBits +: nrOfBits]
//            inReady  - per-channel accept (combinational, one-hot or zero)
//            outValid - output register holds a word
//            outData  - selected word
//            outSel   - index of the channel that supplied outData
//            outReady - downstream accept
// Revision : 1.0 - initial release
// ============================================================================
module mux_arbiter_8 #(
  parameter int nrOfBits = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [7:0]            inValid,
  input  logic [8*nrOfBits-1:0] inData,
  output logic [7:0]            inReady,
  output logic                  outValid,
  output logic [nrOfBits-1:0]   outData,
  output logic [2:0]            outSel,
  input  logic                  outReady
);

  localparam int c_nrOfChannels = 8;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [nrOfBits-1:0] r_outData;
  logic [2:0]          r_outSel;

  logic [2:0]          w_searchBase;
  logic                w_found;
  logic [2:0]          w_grantIdx;
  logic                w_loadAllowed;
  logic                w_grant;

`ifdef MUX_ARBITER_8_ROUND_ROBIN_EN
  logic [2:0] r_ptr;

  // The pointer marks the channel with highest priority on the next search.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr <= 3'd0;
    end else if (w_grant) begin
      r_ptr <= w_grantIdx + 3'd1;  // 7 wraps to 0 through the 3-bit add
    end
  end

  assign w_searchBase = r_ptr;
`else
  assign w_searchBase = 3'd0;
`endif

  // Walk the channels starting at the search base; the first requester wins.
  always_comb begin
    logic [2:0] idx;
    w_found    = 1'b0;
    w_grantIdx = 3'd0;
    idx        = 3'd0;
    for (int k = 0; k < c_nrOfChannels; k++) begin
      idx = w_searchBase + 3'(k);
      if (!w_found && inValid[idx]) begin
        w_found    = 1'b1;
        w_grantIdx = idx;
      end
    end
  end

  // A new word may enter when the register is empty or is being drained
  // in this same cycle.
  assign w_loadAllowed = (r_state == EMPTY) || outReady;
  assign w_grant       = !reset && enable && w_loadAllowed && w_found;
  assign inReady       = w_grant ? (8'd1 << w_grantIdx) : 8'd0;

  always_comb begin
    w_nextState = r_state;
    if (w_grant) begin
      w_nextState = FULL;
    end else if ((r_state == FULL) && outReady) begin
      w_nextState = EMPTY;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= EMPTY;
      r_outData <= '0;
      r_outSel  <= 3'd0;
    end else begin
      r_state <= w_nextState;
      if (w_grant) begin
        r_outData <= inData[int'(w_grantIdx)*nrOfBits +: nrOfBits];
        r_outSel  <= w_grantIdx;
      end
    end
  end

  assign outValid = (r_state == FULL);
  assign outData  = r_outData;
  assign outSel   = r_outSel;

endmodule
`default_nettype wire

// File: tb/tb_mux_arbiter_8.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_arbiter_8
// Purpose  : Self-checking bench for mux_arbiter_8. A driver issues one
//            stimulus vector per cycle, predicts the grant from the
//            arbitration rules and queues the expected output word; a monitor
//            compares each presented output word with the head of the queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_arbiter_8;

  localparam int NB = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [7:0]    inValid;
  logic [8*NB-1:0] inData;
  logic [7:0]    inReady;
  logic          outValid;
  logic [NB-1:0] outData;
  logic [2:0]    outSel;
  logic          outReady;

  mux_arbiter_8 #(.nrOfBits(NB)) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .inValid  (inValid),
    .inData   (inData),
    .inReady  (inReady),
    .outValid (outValid),
    .outData  (outData),
    .outSel   (outSel),
    .outReady (outReady)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [NB-1:0] data;
    logic [2:0]    sel;
  } word_t;

  word_t sbq[$];
  int    nChecks = 0;
  int    nFails  = 0;

  // Reference state
  bit       mFull    = 1'b0;
  int       mPtr     = 0;
  bit       mPrevRst = 1'b0;
  bit       mStarted = 1'b0;
  bit       monOn    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Highest-priority requester under the active policy, or -1.
  function automatic int pickChannel(input logic [7:0] v, input int base);
    for (int k = 0; k < 8; k++) begin
      if (v[(base + k) % 8]) return (base + k) % 8;
    end
    return -1;
  endfunction

  task automatic cycle(input bit rst, input bit en, input logic [7:0] v,
                       input logic [8*NB-1:0] d, input bit ordy);
    int g;
    logic [7:0] expRdy;
    @(negedge clock);
    reset = rst; enable = en; inValid = v; inData = d; outReady = ordy;
    #1;
    if (mStarted) begin
      check("outValid", 64'(outValid), 64'(mFull));
      if (mPrevRst) begin
        check("resetOutData", 64'(outData), 64'd0);
        check("resetOutSel", 64'(outSel), 64'd0);
      end
    end
    g = -1;
    if (!rst && en && (!mFull || ordy)) begin
`ifdef MUX_ARBITER_8_ROUND_ROBIN_EN
      g = pickChannel(v, mPtr);
`else
      g = pickChannel(v, 0);
`endif
    end
    expRdy = (g < 0) ? 8'd0 : 8'(1 << g);
    check("inReady", 64'(inReady), 64'(expRdy));
    if (rst) begin
      mFull = 1'b0;
      mPtr  = 0;
      sbq.delete();
    end else if (g >= 0) begin
      sbq.push_back('{data: d[g*NB +: NB], sel: 3'(g)});
      mFull = 1'b1;
      mPtr  = (g + 1) % 8;
    end else if (mFull && ordy) begin
      mFull = 1'b0;
    end
    mPrevRst = rst;
    mStarted = 1'b1;
  endtask

  // Monitor: every presented word must match the oldest queued prediction,
  // and must stay stable until it is accepted.
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (monOn && !reset && outValid === 1'b1) begin
        if (sbq.size() == 0) begin
          check("unexpectedWord", 64'(outValid), 64'd0);
        end else begin
          check("outData", 64'(outData), 64'(sbq[0].data));
          check("outSel", 64'(outSel), 64'(sbq[0].sel));
          if (outReady) void'(sbq.pop_front());
        end
      end
    end
  end

  function automatic logic [8*NB-1:0] randData();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [8*NB-1:0] d;
    reset = 1'b1; enable = 1'b1; inValid = 8'h00; inData = '0; outReady = 1'b1;
    monOn = 1'b1;

    // Reset with every channel requesting: nothing may be accepted.
    repeat (3) cycle(1, 1, 8'hFF, randData(), 1);

    // All channels held: rotation (or channel 0 forever with fixed priority).
    repeat (10) cycle(0, 1, 8'hFF, randData(), 1);
    repeat (2) cycle(0, 1, 8'h00, randData(), 1);

    // Single channel 0 word 8'hA5.
    d = randData(); d[7:0] = 8'hA5;
    cycle(0, 1, 8'h01, d, 1);
    repeat (2) cycle(0, 1, 8'h00, randData(), 1);

    // Hold ch3 word under back-pressure while ch4 waits, then drain.
    d = randData(); d[3*NB +: NB] = 8'h3C;
    cycle(0, 1, 8'h08, d, 1);
    repeat (4) cycle(0, 1, 8'h10, randData(), 0);
    cycle(0, 1, 8'h10, randData(), 1);
    repeat (2) cycle(0, 1, 8'h00, randData(), 1);

    // Pointer wrap: reach ptr=7 via a ch6 grant, then 7 and 0 compete.
    cycle(0, 1, 8'h40, randData(), 1);
    repeat (3) cycle(0, 1, 8'h81, randData(), 1);
    repeat (2) cycle(0, 1, 8'h00, randData(), 1);

    // enable low blocks new grants; raising it grants channel 1.
    repeat (3) cycle(0, 0, 8'h02, randData(), 1);
    cycle(0, 1, 8'h02, randData(), 1);
    repeat (2) cycle(0, 1, 8'h00, randData(), 1);

    // Mid-operation reset discards the held word.
    cycle(0, 1, 8'h20, randData(), 0);
    cycle(1, 1, 8'hFF, randData(), 0);
    cycle(0, 1, 8'h04, randData(), 1);

    // Randomised traffic with occasional reset.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
            8'($urandom), randData(), ($urandom_range(0, 3) != 0));
    end

    // Drain and confirm nothing predicted was lost.
    repeat (4) cycle(0, 1, 8'h00, randData(), 1);
    check("queueEmpty", 64'(sbq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
`default_nettype wire
